kernel_pr_hls_deadlock_report_unit: RTL

Central arbiter and reporter downstream of the per-process deadlock detect units in the kernel_pr dataflow region. It collects every unit's raw deadlock flag and picks one suspect process. It then launches a dependency-token trace from that process (origin) and broadcasts the global detect flag back to all units. A deadlock is confirmed when the token returns to the suspect while the suspect's flag is still raised; if the flag drops first, or the trace times out, the trace is cancelled and counted as fake.

---
 rtl/kernel_pr_hls_deadlock_report_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/kernel_pr_hls_deadlock_report_unit.sv
// Deadlock arbiter/reporter for the kernel_pr dataflow region: selects one suspect
// process, runs a dependency-token trace from it, and confirms or cancels the suspicion.
module kernel_pr_hls_deadlock_report_unit #(
  parameter int PROC_NUM       = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_in_vec,
  input  logic [PROC_NUM-1:0] token_back_vec,
  input  logic                report_ack,
  output logic                dl_detect_out,
  output logic [PROC_NUM-1:0] origin_vec,
  output logic                token_clear,
  output logic                dl_report_vld,
  output logic [ID_W-1:0]     dl_proc_id,
  output logic [CNT_W-1:0]    fake_cnt
);

  localparam int TC_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TC_W-1:0] TC_MAX  = TC_W'(TIMEOUT_CYCLES);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, TRACE, REPORT, DRAIN} state_t;

  state_t              state, state_next;
  logic [TC_W-1:0]     trace_cnt, cnt_next;
  logic [ID_W-1:0]     id_next, low_id;
  logic                detect_next, clear_next, vld_next;
  logic [PROC_NUM-1:0] origin_next;
  logic [CNT_W-1:0]    fake_next;
  logic                suspect_flag, suspect_token, fake_hit, confirm_hit;

  // Lowest set index wins: scan downwards so the last assignment is the lowest bit.
  always_comb begin
    low_id = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (dl_in_vec[i]) low_id = ID_W'(i);
    end
  end

  assign suspect_flag  = dl_in_vec[dl_proc_id];
  assign suspect_token = token_back_vec[dl_proc_id];

  always_comb begin
    state_next  = state;
    cnt_next    = trace_cnt;
    id_next     = dl_proc_id;
    detect_next = dl_detect_out;
    origin_next = '0;
    clear_next  = 1'b0;
    vld_next    = dl_report_vld;
    fake_next   = fake_cnt;
    fake_hit    = 1'b0;
    confirm_hit = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (|dl_in_vec) begin
          id_next     = low_id;
          origin_next = PROC_NUM'(1) << low_id;
          detect_next = 1'b1;
          state_next  = TRACE;
        end
      end
      TRACE: begin
        if (trace_cnt != TC_MAX) cnt_next = trace_cnt + TC_W'(1);
        // A token seen in the origin cycle cannot be a real return: unit tokens are registered.
        if (!suspect_flag)                          fake_hit    = 1'b1;
        else if (suspect_token && trace_cnt != '0)  confirm_hit = 1'b1;
        else if (trace_cnt == TC_LAST)              fake_hit    = 1'b1;
        if (fake_hit) begin
          state_next  = DRAIN;
          clear_next  = 1'b1;
          detect_next = 1'b0;
          if (fake_cnt != {CNT_W{1'b1}}) fake_next = fake_cnt + CNT_W'(1);
        end else if (confirm_hit) begin
          state_next = REPORT;
          clear_next = 1'b1;
          vld_next   = 1'b1;
        end
      end
      REPORT: begin
        if (report_ack) begin
          vld_next    = 1'b0;
          detect_next = 1'b0;
          state_next  = DRAIN;
        end
      end
      DRAIN: begin
        detect_next = 1'b0;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      trace_cnt     <= '0;
      dl_proc_id    <= '0;
      dl_detect_out <= 1'b0;
      origin_vec    <= '0;
      token_clear   <= 1'b0;
      dl_report_vld <= 1'b0;
      fake_cnt      <= '0;
    end else begin
      state         <= state_next;
      trace_cnt     <= cnt_next;
      dl_proc_id    <= id_next;
      dl_detect_out <= detect_next;
      origin_vec    <= origin_next;
      token_clear   <= clear_next;
      dl_report_vld <= vld_next;
      fake_cnt      <= fake_next;
    end
  end

endmodule
